// File: rtl/inst_cache_dm.sv
// Direct-mapped instruction cache with multi-word lines, byte-reversing refill and fence.i invalidate.
// Optional feature: define ICACHE_PERF_CNT_EN to add saturating hit_count / miss_count outputs.

`ifndef I_CACHE_RESTING
`define I_CACHE_RESTING  2'b00
`endif
`ifndef I_CACHE_WORKING
`define I_CACHE_WORKING  2'b01
`endif
`ifndef I_CACHE_STALL
`define I_CACHE_STALL    2'b10
`endif
`ifndef IF_FINISHED
`define IF_FINISHED      2'b11
`endif
`ifndef MEM_RESTING
`define MEM_RESTING      2'b00
`endif
`ifndef MEM_INST_WORKING
`define MEM_INST_WORKING 2'b01
`endif
`ifndef MEM_DATA_WORKING
`define MEM_DATA_WORKING 2'b10
`endif
`ifndef MEM_NOP
`define MEM_NOP          2'b00
`endif
`ifndef MEM_READ
`define MEM_READ         2'b01
`endif

module inst_cache_dm #(
  parameter int ADDR_WIDTH     = 17,
  parameter int LEN            = 32,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  inst_fetch_enabled,
  input  logic                  invalidate_all,
  output logic [LEN-1:0]        instruction,
  output logic [1:0]            inst_fetch_status,
  input  logic [LEN-1:0]        mem_data,
  input  logic [1:0]            mem_status,
  output logic [ADDR_WIDTH-1:0] mem_vis_addr,
  output logic [1:0]            mem_vis_signal
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS = ADDR_WIDTH - 2 - OFF_BITS - IDX_BITS;
  localparam int OFF_W    = (OFF_BITS > 0) ? OFF_BITS : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESPOND
  } state_t;

  // A zero-width offset (single-word lines) collapses to a constant-0 one-bit field.
  function automatic logic [OFF_W-1:0] offsetOf(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] s;
    s = (a >> 2) & ADDR_WIDTH'(WORDS_PER_LINE - 1);
    return s[OFF_W-1:0];
  endfunction

  function automatic logic [IDX_BITS-1:0] indexOf(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] s;
    s = a >> (2 + OFF_BITS);
    return s[IDX_BITS-1:0];
  endfunction

  function automatic logic [TAG_BITS-1:0] tagOf(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] s;
    s = a >> (2 + OFF_BITS + IDX_BITS);
    return s[TAG_BITS-1:0];
  endfunction

  function automatic logic [LEN-1:0] byteSwap(input logic [LEN-1:0] d);
    logic [LEN-1:0] r;
    r = '0;
    for (int i = 0; i < LEN / 8; i++) begin
      r[8*i +: 8] = d[LEN-8-8*i +: 8];
    end
    return r;
  endfunction

  state_t                  state_q;
  logic [NUM_LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0]     tag_q   [NUM_LINES];
  logic [LEN-1:0]          data_q  [NUM_LINES][WORDS_PER_LINE];
  logic [ADDR_WIDTH-1:0]   reqAddr_q;
  logic [OFF_W-1:0]        cnt_q;
  logic                    invPending_q;
  logic [LEN-1:0]          instr_q;
  logic [1:0]              status_q;
  logic [1:0]              memSig_q;
  logic [ADDR_WIDTH-1:0]   memAddr_q;

  logic [IDX_BITS-1:0]     lkIdx;
  logic [OFF_W-1:0]        lkOff;
  logic [TAG_BITS-1:0]     lkTag;
  logic                    lookupHit;
  logic [ADDR_WIDTH-1:0]   lineBase;
  logic [IDX_BITS-1:0]     fillIdx;
  logic [OFF_W-1:0]        fillOff;
  logic [TAG_BITS-1:0]     fillTag;
  logic [LEN-1:0]          fillWord;
  logic                    lastWord;

  // An invalidate arriving with the request wins over the lookup, forcing a miss.
  always_comb begin
    lkIdx     = indexOf(inst_addr);
    lkOff     = offsetOf(inst_addr);
    lkTag     = tagOf(inst_addr);
    lookupHit = valid_q[lkIdx] && (tag_q[lkIdx] == lkTag) && !invalidate_all;
    lineBase  = inst_addr & ~ADDR_WIDTH'(WORDS_PER_LINE * 4 - 1);
    fillIdx   = indexOf(reqAddr_q);
    fillOff   = offsetOf(reqAddr_q);
    fillTag   = tagOf(reqAddr_q);
    fillWord  = byteSwap(mem_data);
    lastWord  = (cnt_q == OFF_W'(WORDS_PER_LINE - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      reqAddr_q    <= '0;
      cnt_q        <= '0;
      invPending_q <= 1'b0;
      instr_q      <= '0;
      status_q     <= `I_CACHE_RESTING;
      memSig_q     <= `MEM_NOP;
      memAddr_q    <= '0;
    end else begin
      memSig_q <= `MEM_NOP;
      case (state_q)
        S_IDLE: begin
          if (invalidate_all) valid_q <= '0;
          if (inst_fetch_enabled) begin
            reqAddr_q <= inst_addr;
            if (lookupHit) begin
              instr_q  <= data_q[lkIdx][lkOff];
              status_q <= `IF_FINISHED;
              state_q  <= S_RESPOND;
            end else begin
              status_q  <= `I_CACHE_WORKING;
              memAddr_q <= lineBase;
              cnt_q     <= '0;
              state_q   <= S_REQ;
            end
          end else begin
            status_q <= `I_CACHE_RESTING;
          end
        end
        S_REQ: begin
          if (invalidate_all) invPending_q <= 1'b1;
          if (mem_status == `MEM_RESTING) begin
            memSig_q <= `MEM_READ;
            status_q <= `I_CACHE_WORKING;
            state_q  <= S_WAIT;
          end else begin
            status_q <= `I_CACHE_STALL;
          end
        end
        S_WAIT: begin
          if (invalidate_all) invPending_q <= 1'b1;
          case (mem_status)
            `MEM_INST_WORKING: begin
              data_q[fillIdx][cnt_q] <= fillWord;
              if (lastWord) begin
                tag_q[fillIdx]   <= fillTag;
                valid_q[fillIdx] <= 1'b1;
                // The last word is still in flight, so it must bypass the array.
                instr_q  <= (cnt_q == fillOff) ? fillWord : data_q[fillIdx][fillOff];
                status_q <= `IF_FINISHED;
                state_q  <= S_RESPOND;
              end else begin
                cnt_q     <= cnt_q + OFF_W'(1);
                memAddr_q <= memAddr_q + ADDR_WIDTH'(4);
                state_q   <= S_REQ;
              end
            end
            `MEM_DATA_WORKING: begin
              status_q <= `I_CACHE_STALL;
              state_q  <= S_REQ;
            end
            default: ;
          endcase
        end
        S_RESPOND: begin
          // A fence.i seen during the refill also discards the line just filled.
          if (invalidate_all || invPending_q) begin
            valid_q      <= '0;
            invPending_q <= 1'b0;
          end
          status_q <= `I_CACHE_RESTING;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instruction       = instr_q;
  assign inst_fetch_status = status_q;
  assign mem_vis_addr      = memAddr_q;
  assign mem_vis_signal    = memSig_q;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hitCount_q, hitCount_d;
  logic [31:0] missCount_q, missCount_d;

  always_comb begin
    hitCount_d  = hitCount_q;
    missCount_d = missCount_q;
    if (state_q == S_IDLE && inst_fetch_enabled) begin
      if (lookupHit) begin
        if (hitCount_q != 32'hFFFF_FFFF) hitCount_d = hitCount_q + 32'd1;
      end else begin
        if (missCount_q != 32'hFFFF_FFFF) missCount_d = missCount_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else begin
      hitCount_q  <= hitCount_d;
      missCount_q <= missCount_d;
    end
  end

  assign hit_count  = hitCount_q;
  assign miss_count = missCount_q;
`endif

endmodule

// File: tb/tb_inst_cache_dm.sv
// Directed bench for inst_cache_dm: reset, cold miss, hit, conflict, preemption and fence.i during refill.
// Build with ICACHE_PERF_CNT_EN defined to also check the hit/miss counters.

`ifndef I_CACHE_RESTING
`define I_CACHE_RESTING  2'b00
`endif
`ifndef I_CACHE_WORKING
`define I_CACHE_WORKING  2'b01
`endif
`ifndef I_CACHE_STALL
`define I_CACHE_STALL    2'b10
`endif
`ifndef IF_FINISHED
`define IF_FINISHED      2'b11
`endif
`ifndef MEM_RESTING
`define MEM_RESTING      2'b00
`endif
`ifndef MEM_INST_WORKING
`define MEM_INST_WORKING 2'b01
`endif
`ifndef MEM_DATA_WORKING
`define MEM_DATA_WORKING 2'b10
`endif
`ifndef MEM_NOP
`define MEM_NOP          2'b00
`endif
`ifndef MEM_READ
`define MEM_READ         2'b01
`endif

module tb_inst_cache_dm;
  localparam int AW  = 17;
  localparam int LEN = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [AW-1:0]  inst_addr;
  logic           inst_fetch_enabled;
  logic           invalidate_all;
  logic [LEN-1:0] instruction;
  logic [1:0]     inst_fetch_status;
  logic [LEN-1:0] mem_data;
  logic [1:0]     mem_status;
  logic [AW-1:0]  mem_vis_addr;
  logic [1:0]     mem_vis_signal;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]    hit_count;
  logic [31:0]    miss_count;
`endif

  int             errors = 0;
  int             checks = 0;
  logic [AW-1:0]  readLog[$];
  int             preemptLeft = 0;
  logic           preemptArm = 1'b0;
  logic [AW-1:0]  preemptAddr = '0;
  logic           stallSeen = 1'b0;

  always #5 clk = ~clk;

  inst_cache_dm dut (
    .clk               (clk),
    .rst               (rst),
    .inst_addr         (inst_addr),
    .inst_fetch_enabled(inst_fetch_enabled),
    .invalidate_all    (invalidate_all),
    .instruction       (instruction),
    .inst_fetch_status (inst_fetch_status),
    .mem_data          (mem_data),
    .mem_status        (mem_status),
    .mem_vis_addr      (mem_vis_addr),
    .mem_vis_signal    (mem_vis_signal)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count         (hit_count),
    .miss_count        (miss_count)
`endif
  );

  // Raw memory image: 0x14 holds 0x78563412, other words differ in bytes 0 and 2.
  function automatic logic [31:0] memWord(input logic [AW-1:0] a);
    logic [31:0] x;
    x = {8'h00, a[15:8], 8'h00, a[7:0] ^ 8'h14};
    return 32'h78563412 ^ x;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Memory answers during the cycle after each READ; optionally preempts one read for 3 cycles.
  always @(negedge clk) begin
    if (rst) begin
      mem_status  = `MEM_RESTING;
      preemptLeft = 0;
    end else if (preemptLeft > 0) begin
      mem_status = `MEM_DATA_WORKING;
      preemptLeft--;
    end else if (mem_vis_signal == `MEM_READ) begin
      readLog.push_back(mem_vis_addr);
      if (preemptArm && mem_vis_addr == preemptAddr) begin
        preemptArm  = 1'b0;
        mem_status  = `MEM_DATA_WORKING;
        preemptLeft = 2;
      end else begin
        mem_status = `MEM_INST_WORKING;
        mem_data   = memWord(mem_vis_addr);
      end
    end else begin
      mem_status = `MEM_RESTING;
    end
  end

  // Presents one request for a single cycle, then scrambles the address to show it is ignored.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic inv, output logic [1:0] firstStatus);
    readLog.delete();
    stallSeen          = 1'b0;
    inst_addr          = addr;
    inst_fetch_enabled = 1'b1;
    invalidate_all     = inv;
    @(negedge clk);
    inst_fetch_enabled = 1'b0;
    invalidate_all     = 1'b0;
    inst_addr          = ~addr;
    firstStatus        = inst_fetch_status;
  endtask

  task automatic waitFinished(input string tag, input int budget, output logic [31:0] instr);
    int n;
    n = 0;
    while (inst_fetch_status != `IF_FINISHED && n < budget) begin
      @(negedge clk);
      n++;
      if (inst_fetch_status == `I_CACHE_STALL) stallSeen = 1'b1;
    end
    checkOutput({tag, "_finished"}, 32'(inst_fetch_status), 32'(`IF_FINISHED));
    instr = instruction;
    @(negedge clk);
    checkOutput({tag, "_respond_1cyc"}, 32'(inst_fetch_status), 32'(`I_CACHE_RESTING));
  endtask

  task automatic checkReads(input string tag, input int n, input logic [AW-1:0] e0, input logic [AW-1:0] e1,
                            input logic [AW-1:0] e2, input logic [AW-1:0] e3, input logic [AW-1:0] e4);
    logic [AW-1:0] e [5];
    e = '{e0, e1, e2, e3, e4};
    checkOutput({tag, "_nreads"}, 32'(readLog.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_read%0d", tag, i), (i < readLog.size()) ? 32'(readLog[i]) : 32'hFFFF_FFFF,
                  32'(e[i]));
    end
  endtask

  initial begin
    logic [1:0]  st;
    logic [31:0] instr;

    rst                = 1'b1;
    inst_addr          = '0;
    inst_fetch_enabled = 1'b0;
    invalidate_all     = 1'b0;
    mem_data           = '0;
    mem_status         = `MEM_RESTING;
    repeat (3) @(negedge clk);
    checkOutput("rst_status", 32'(inst_fetch_status), 32'(`I_CACHE_RESTING));
    checkOutput("rst_signal", 32'(mem_vis_signal), 32'(`MEM_NOP));
    checkOutput("rst_addr", 32'(mem_vis_addr), 32'h0);
    checkOutput("rst_instr", instruction, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("idle_status%0d", i), 32'(inst_fetch_status), 32'(`I_CACHE_RESTING));
      checkOutput($sformatf("idle_signal%0d", i), 32'(mem_vis_signal), 32'(`MEM_NOP));
    end

    // Cold miss on 0x14 refills line 0x10..0x1C in order.
    applyStimulus(17'h00014, 1'b0, st);
    checkOutput("cold_first", 32'(st), 32'(`I_CACHE_WORKING));
    waitFinished("cold", 100, instr);
    checkOutput("cold_instr", instr, 32'h12345678);
    checkReads("cold", 4, 17'h00010, 17'h00014, 17'h00018, 17'h0001C, 17'h0);

    // Hit on the last word of the refilled line.
    applyStimulus(17'h0001C, 1'b0, st);
    checkOutput("hit_first", 32'(st), 32'(`IF_FINISHED));
    checkOutput("hit_instr", instruction, 32'h1A345678);
    @(negedge clk);
    checkOutput("hit_respond_1cyc", 32'(inst_fetch_status), 32'(`I_CACHE_RESTING));
    checkOutput("hit_nreads", 32'(readLog.size()), 32'd0);

    // Same index, new tag: full refill of the conflicting line.
    applyStimulus(17'h00110, 1'b0, st);
    checkOutput("conf_first", 32'(st), 32'(`I_CACHE_WORKING));
    waitFinished("conf", 100, instr);
    checkOutput("conf_instr", instr, 32'h16345778);
    checkReads("conf", 4, 17'h00110, 17'h00114, 17'h00118, 17'h0011C, 17'h0);

    // 0x10 misses again; preempt the 0x14 read and raise fence.i while the refill runs.
    preemptArm  = 1'b1;
    preemptAddr = 17'h00014;
    applyStimulus(17'h00010, 1'b0, st);
    checkOutput("pre_first", 32'(st), 32'(`I_CACHE_WORKING));
    invalidate_all = 1'b1;
    @(negedge clk);
    invalidate_all = 1'b0;
    waitFinished("pre", 100, instr);
    checkOutput("pre_instr", instr, 32'h16345678);
    checkOutput("pre_stall_seen", 32'(stallSeen), 32'd1);
    checkReads("pre", 5, 17'h00010, 17'h00014, 17'h00014, 17'h00018, 17'h0001C);

    // The line filled under a pending invalidate must not survive it.
    applyStimulus(17'h00010, 1'b0, st);
    checkOutput("inv_first", 32'(st), 32'(`I_CACHE_WORKING));
    waitFinished("inv", 100, instr);
    checkOutput("inv_instr", instr, 32'h16345678);
    checkOutput("inv_nreads", 32'(readLog.size()), 32'd4);

`ifdef ICACHE_PERF_CNT_EN
    checkOutput("perf_hits", hit_count, 32'd1);
    checkOutput("perf_misses", miss_count, 32'd4);
`endif

    // Fence.i with a request that would hit turns it into a miss; last word comes via bypass.
    applyStimulus(17'h0001C, 1'b1, st);
    checkOutput("idleinv_first", 32'(st), 32'(`I_CACHE_WORKING));
    waitFinished("idleinv", 100, instr);
    checkOutput("idleinv_instr", instr, 32'h1A345678);
    checkOutput("idleinv_nreads", 32'(readLog.size()), 32'd4);

`ifdef ICACHE_PERF_CNT_EN
    checkOutput("perf_misses_final", miss_count, 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_cache_dm.md
Name: inst_cache_dm

Overview:
- Parametrised direct-mapped instruction cache with multi-word lines; replaces the 2-entry fully-associative fetch buffer.
- Sits between the instruction-fetch stage and the main-memory controller.
- Uses the same fetch status / memory-visit signalling, so the fetch unit and memory controller are unchanged.
- Byte-reorders every memory word (little-endian swap) before storing it. Adds line refill and a global invalidate port (fence.i).

Parameters:
- ADDR_WIDTH, 17, byte-address width.
- LEN, 32, instruction/word width.
- NUM_LINES, 16, number of lines; power of two, >=2.
- WORDS_PER_LINE, 4, words per line; power of two, >=1.
- Derived: OFF_BITS = log2(WORDS_PER_LINE), IDX_BITS = log2(NUM_LINES), TAG_BITS = ADDR_WIDTH-2-OFF_BITS-IDX_BITS.

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- inst_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
- inst_fetch_enabled  in  1  fetch request
- invalidate_all  in  1  clear all valid bits (fence.i)
- instruction  out  LEN  reordered instruction; valid while status = `IF_FINISHED`
- inst_fetch_status  out  2  `I_CACHE_RESTING` / `I_CACHE_WORKING` / `I_CACHE_STALL` / `IF_FINISHED`
- mem_data  in  LEN  raw word from memory
- mem_status  in  2  `MEM_RESTING` / `MEM_INST_WORKING` / `MEM_DATA_WORKING`
- mem_vis_addr  out  ADDR_WIDTH  word-aligned refill address
- mem_vis_signal  out  2  `MEM_NOP` / `MEM_READ`

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst=1 at posedge), from any state including mid-refill:
  - all valid bits = 0; state = IDLE; word counter = 0.
  - instruction = 0; inst_fetch_status = `I_CACHE_RESTING`; mem_vis_signal = `MEM_NOP`; mem_vis_addr = 0.
  - An in-flight refill is abandoned; its line stays invalid.
- Address split: offset = addr[2 +: OFF_BITS], index = addr[2+OFF_BITS +: IDX_BITS], tag = remaining upper bits.
- Reorder: stored word = {d[7:0], d[15:8], d[23:16], d[31:24]}.
- IDLE:
  - If inst_fetch_enabled: latch the address, then do a combinational lookup.
  - Hit: instruction <= data[index][offset], status <= `IF_FINISHED`, go to RESPOND. Hit latency is 1 cycle.
  - Miss: status <= `I_CACHE_WORKING`, mem_vis_addr <= line base (offset = 0, bits [1:0] = 0), counter <= 0, go to REQ.
  - No request: status <= `I_CACHE_RESTING`.
- REQ:
  - mem_status = `MEM_RESTING`: mem_vis_signal <= `MEM_READ` for exactly one cycle, status `I_CACHE_WORKING`, go to WAIT.
  - Otherwise: mem_vis_signal <= `MEM_NOP`, status <= `I_CACHE_STALL`, stay in REQ.
- WAIT (mem_vis_signal <= `MEM_NOP`):
  - `MEM_INST_WORKING`: store reordered mem_data at [index][counter].
    - counter = WORDS_PER_LINE-1: write tag, set valid, instruction <= requested word (bypass if it is the current word), status <= `IF_FINISHED`, go to RESPOND.
    - Otherwise: counter+1, mem_vis_addr+4, go to REQ.
  - `MEM_DATA_WORKING`: data port preempted; status <= `I_CACHE_STALL`, go to REQ and retry the same word.
  - `MEM_RESTING`: stay in WAIT.
- RESPOND:
  - `IF_FINISHED` is held exactly one cycle, then IDLE with status `I_CACHE_RESTING`.
  - inst_fetch_enabled is ignored in RESPOND, so back-to-back hits have a 2-cycle throughput.
- Request changes: inst_fetch_enabled dropping, or inst_addr changing, after acceptance has no effect. The refill completes and the response is still issued.
- Invalidate:
  - In IDLE/RESPOND: all valid bits clear at that posedge. It overrides a same-cycle hit, which is then treated as a miss.
  - During REQ/WAIT: latched as pending. The refill completes and responds normally; all valid bits (including the new line) clear on the RESPOND cycle.
- Tag/data arrays are not reset; only valid bits are.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- When defined, adds two outputs: hit_count and miss_count, each 32 bits.
  - Both are cleared by rst and saturate at 0xFFFFFFFF.
  - hit_count increments on each IDLE hit; miss_count increments on each IDLE miss.
  - A request converted to a miss by invalidate counts as a miss.
- When undefined, neither the ports nor the counters exist, and behaviour is otherwise identical.

Test Plan:
- Reset then idle: after rst, status = `I_CACHE_RESTING` and mem_vis_signal = `MEM_NOP` for 10 cycles with no request.
- Cold miss (defaults): fetch 0x00014, memory answers 1 cycle after each READ.
  - Required: READs to 0x00010, 0x00014, 0x00018, 0x0001C in order.
  - Then `IF_FINISHED` with the byte-swapped word of 0x00014 (mem 0x78563412 -> 0x12345678).
- Hit: fetch 0x0001C after the cold miss -> `IF_FINISHED` the next cycle, no `MEM_READ`, value from the refill.
- Conflict: fetch 0x00110 (same index 1, new tag) -> full refill of 0x00110..0x0011C; a following fetch of 0x00010 misses again.
- Preemption: mem_status = `MEM_DATA_WORKING` for 3 cycles mid-refill -> `I_CACHE_STALL` shown, the same word address is re-requested, final data is correct.
- Invalidate during refill, plus perf counters: the line still responds; the next fetch of the same address misses. With ICACHE_PERF_CNT_EN: hit_count = 1, miss_count = 4 over the sequence above.
